// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction-fetch front end.
package fetch_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  // Word-aligned and inside the instruction memory.
  function automatic logic pc_legal(input logic [XLEN-1:0] pc, input int unsigned mem_bytes);
    return (pc[1:0] == 2'b00) && (pc <= (mem_bytes - 32'd4));
  endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// Two-entry FIFO holding fetched {pc, instr} pairs until decode accepts them.
module fetch_skid_buffer
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         resetn,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t push_data,
  output fetch_entry_t head,
  output logic [1:0]   count
);

  fetch_entry_t r_mem [2];
  logic         r_rd_ptr;
  logic         r_wr_ptr;
  logic [1:0]   r_count;
  logic         w_pop;

  assign w_pop = pop && (r_count != 2'd0);
  assign head  = r_mem[r_rd_ptr];
  assign count = r_count;

  // Flush wins over push so wrong-path words never land.
  always_ff @(posedge clk) begin
    if (!resetn || flush) begin
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (push)  r_wr_ptr <= ~r_wr_ptr;
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      r_count <= r_count + {1'b0, push} - {1'b0, w_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) r_mem[r_wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_controller.sv
// Front-end fetch sequencer: owns the PC, issues to a one-cycle-latency
// instruction memory, buffers responses for decode and handles redirects.
module fetch_controller
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0004,
  parameter int unsigned     MEM_BYTES = 128
) (
  input  logic            clk,
  input  logic            resetn,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            fault,
  output logic [XLEN-1:0] fault_pc
);

  fetch_state_t    r_state;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_issued_pc;
  logic [XLEN-1:0] r_fault_pc;
  logic            r_inflight;
  logic            r_fault;

  logic [1:0]      w_count;
  fetch_entry_t    w_head;
  fetch_entry_t    w_push_data;
  logic            w_pop;
  logic            w_push;
  logic            w_pc_legal;
  logic            w_credit;
  logic            w_slot;
  logic            w_issue;
  logic            w_seq_fault;

  assign if_valid   = (w_count != 2'd0);
  assign w_pop      = if_valid && if_ready;
  assign w_pc_legal = pc_legal(r_pc, MEM_BYTES);

  // Buffered plus in-flight words, after this cycle's pop, must leave room for one more.
  assign w_credit    = (({1'b0, w_count} + {2'b00, r_inflight} - {2'b00, w_pop}) < 3'd2);
  assign w_slot      = (r_state == RUN) && !redirect_valid && w_credit;
  assign w_issue     = w_slot && w_pc_legal;
  assign w_seq_fault = w_slot && !w_pc_legal;
  assign w_push      = r_inflight && !redirect_valid;

  assign w_push_data.pc    = r_issued_pc;
  assign w_push_data.instr = imem_rdata;

  fetch_skid_buffer u_buf (
    .clk       (clk),
    .resetn    (resetn),
    .push      (w_push),
    .pop       (w_pop),
    .flush     (redirect_valid),
    .push_data (w_push_data),
    .head      (w_head),
    .count     (w_count)
  );

  assign imem_addr = r_pc;
  assign if_instr  = if_valid ? w_head.instr : '0;
  assign if_pc     = if_valid ? w_head.pc    : '0;
  assign fault     = r_fault;
  assign fault_pc  = r_fault_pc;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state    <= IDLE;
      r_pc       <= RESET_PC;
      r_inflight <= 1'b0;
      r_fault    <= 1'b0;
      r_fault_pc <= '0;
    end else begin
      r_inflight <= w_issue;
      if (redirect_valid) begin
        r_pc <= redirect_pc;
        if (pc_legal(redirect_pc, MEM_BYTES)) begin
          r_state <= RUN;
          r_fault <= 1'b0;
        end else begin
          r_state    <= HALT;
          r_fault    <= 1'b1;
          r_fault_pc <= redirect_pc;
        end
      end else begin
        case (r_state)
          IDLE: r_state <= RUN;
          RUN: begin
            if (w_issue) begin
              r_pc <= r_pc + 32'd4;
            end else if (w_seq_fault) begin
              r_state    <= HALT;
              r_fault    <= 1'b1;
              r_fault_pc <= r_pc;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_issue) r_issued_pc <= r_pc;
  end

endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller: directed scenarios plus random traffic, all
// compared every cycle against a queue-based reference model.
module tb_fetch_controller;

  localparam int unsigned MEMB = 128;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fault;
  logic [31:0] fault_pc;

  logic [31:0] mem [32];

  int n_chk  = 0;
  int n_fail = 0;

  fetch_controller #(.RESET_PC(32'h0000_0004), .MEM_BYTES(MEMB)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fault          (fault),
    .fault_pc       (fault_pc)
  );

  always #5 clk = ~clk;

  // Registered-read instruction memory; outputs zero while in reset.
  always @(posedge clk) imem_rdata <= resetn ? mem[imem_addr[6:2]] : 32'h0;

  // Reference model: what decode should see, as a queue of PCs.
  logic [31:0] q[$];
  logic [31:0] m_pc, m_ppc, m_fpc;
  bit          m_pend, m_fault, m_rst;
  int          m_mode; // 0 bubble, 1 running, 2 halted

  function automatic bit legal(input logic [31:0] a);
    return ((a % 4) == 0) && (a <= MEMB - 4);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit rst_n, input bit rdy, input bit rv, input logic [31:0] rpc);
    bit pop;
    int occ;
    bit new_pend;
    new_pend = 1'b0;
    m_rst = !rst_n;
    if (!rst_n) begin
      m_pc = 32'h4; m_mode = 0; q.delete(); m_pend = 0; m_fault = 0; m_fpc = 0;
      return;
    end
    pop = (q.size() > 0) && rdy;
    occ = q.size() + int'(m_pend) - int'(pop);
    if (pop) void'(q.pop_front());
    if (rv) begin
      q.delete();
      m_pc = rpc;
      if (legal(rpc)) begin m_mode = 1; m_fault = 0; end
      else begin m_mode = 2; m_fault = 1; m_fpc = rpc; end
    end else begin
      if (m_pend) q.push_back(m_ppc);
      if (m_mode == 0) m_mode = 1;
      else if (m_mode == 1 && occ < 2) begin
        if (legal(m_pc)) begin new_pend = 1; m_ppc = m_pc; m_pc = m_pc + 4; end
        else begin m_mode = 2; m_fault = 1; m_fpc = m_pc; end
      end
    end
    m_pend = new_pend;
  endtask

  task automatic model_check();
    chk("if_valid", {31'b0, if_valid}, {31'b0, q.size() > 0});
    chk("imem_addr", imem_addr, m_pc);
    chk("fault", {31'b0, fault}, {31'b0, m_fault});
    chk("fault_pc", fault_pc, m_fpc);
    if (q.size() > 0) begin
      chk("if_pc", if_pc, q[0]);
      chk("if_instr", if_instr, mem[q[0] >> 2]);
    end else if (m_rst) begin
      chk("rst_if_pc", if_pc, 32'h0);
      chk("rst_if_instr", if_instr, 32'h0);
    end
  endtask

  task automatic tick(input bit rst_n, input bit rdy, input bit rv, input logic [31:0] rpc);
    resetn = rst_n; if_ready = rdy; redirect_valid = rv; redirect_pc = rpc;
    model_step(rst_n, rdy, rv, rpc);
    @(negedge clk);
    model_check();
  endtask

  initial begin
    logic [31:0] tgt;
    int r;
    for (int i = 0; i < 32; i++) mem[i] = $urandom;
    mem[0] = 32'h0000_0013;
    mem[1] = 32'h00F0_0093;
    mem[2] = 32'h03A0_C113;
    mem[4] = 32'h0011_A233;
    mem[5] = 32'h00B2_1293;
    resetn = 0; if_ready = 0; redirect_valid = 0; redirect_pc = 0;

    // Reset state and first stream
    tick(0, 1, 0, 0); tick(0, 1, 0, 0);
    chk("rst_valid", {31'b0, if_valid}, 32'h0);
    chk("rst_fault", {31'b0, fault}, 32'h0);
    chk("rst_addr", imem_addr, 32'h4);
    chk("rst_pc", if_pc, 32'h0);
    tick(1, 1, 0, 0);
    chk("t1_addr", imem_addr, 32'h4);
    tick(1, 1, 0, 0);
    chk("t1_bubble", {31'b0, if_valid}, 32'h0);
    tick(1, 1, 0, 0);
    chk("t1_valid", {31'b0, if_valid}, 32'h1);
    chk("t1_pc", if_pc, 32'h4);
    chk("t1_instr", if_instr, 32'h00F0_0093);
    chk("t1_model_head", q[0], 32'h4);
    tick(1, 1, 0, 0);
    chk("t1_pc2", if_pc, 32'h8);
    chk("t1_instr2", if_instr, 32'h03A0_C113);

    // Back-pressure fills the buffer and stalls issue
    tick(0, 0, 0, 0);
    repeat (8) tick(1, 0, 0, 0);
    chk("t2_hold_pc", if_pc, 32'h4);
    chk("t2_hold_instr", if_instr, 32'h00F0_0093);
    chk("t2_stall_addr", imem_addr, 32'hC);
    tick(1, 1, 0, 0);
    chk("t2_next_pc", if_pc, 32'h8);

    // Redirect kills the in-flight word for pc 12
    tick(1, 1, 1, 32'd16);
    chk("t3_flush", {31'b0, if_valid}, 32'h0);
    chk("t3_addr", imem_addr, 32'd16);
    tick(1, 1, 0, 0);
    chk("t3_gap", {31'b0, if_valid}, 32'h0);
    tick(1, 1, 0, 0);
    chk("t3_pc", if_pc, 32'd16);
    chk("t3_instr", if_instr, 32'h0011_A233);

    // Misaligned redirect halts; legal redirect resumes
    tick(1, 1, 1, 32'd6);
    chk("t4_fault", {31'b0, fault}, 32'h1);
    chk("t4_fault_pc", fault_pc, 32'd6);
    repeat (3) tick(1, 1, 0, 0);
    chk("t4_no_issue", imem_addr, 32'd6);
    chk("t4_empty", {31'b0, if_valid}, 32'h0);
    tick(1, 1, 1, 32'd20);
    chk("t4_clear", {31'b0, fault}, 32'h0);
    tick(1, 1, 0, 0); tick(1, 1, 0, 0);
    chk("t4_pc", if_pc, 32'd20);
    chk("t4_instr", if_instr, 32'h00B2_1293);

    // Run off the end of memory
    tick(1, 1, 1, 32'd116);
    tick(1, 1, 0, 0); tick(1, 1, 0, 0);
    chk("t5_pc116", if_pc, 32'd116);
    tick(1, 1, 0, 0);
    chk("t5_pc120", if_pc, 32'd120);
    tick(1, 1, 0, 0);
    chk("t5_pc124", if_pc, 32'd124);
    chk("t5_fault", {31'b0, fault}, 32'h1);
    chk("t5_fault_pc", fault_pc, 32'd128);
    tick(1, 1, 0, 0);
    chk("t5_drained", {31'b0, if_valid}, 32'h0);

    // Reset with work buffered and in flight
    tick(1, 0, 1, 32'd40); tick(1, 0, 0, 0); tick(1, 0, 0, 0);
    tick(0, 0, 0, 0);
    chk("t6_valid", {31'b0, if_valid}, 32'h0);
    chk("t6_fault", {31'b0, fault}, 32'h0);
    chk("t6_addr", imem_addr, 32'h4);
    tick(1, 1, 0, 0); tick(1, 1, 0, 0); tick(1, 1, 0, 0);
    chk("t6_restart", if_pc, 32'h4);

    // Random traffic
    repeat (3000) begin
      r = $urandom_range(0, 99);
      if (r < 50)      tgt = $urandom_range(0, 31) * 4;
      else if (r < 70) tgt = $urandom_range(26, 31) * 4;
      else if (r < 85) tgt = ($urandom_range(0, 31) * 4) | $urandom_range(1, 3);
      else             tgt = $urandom_range(32, 1024) * 4;
      tick($urandom_range(0, 99) != 0, $urandom_range(0, 99) < 75,
           $urandom_range(0, 99) < 6, tgt);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
